// File: rtl/spi_reg_frontend_if.sv
// spi_reg_frontend_if
//   Bundles the SPI pins and the PWM configuration outputs of spi_reg_frontend.
//   When READBACK_EN is defined, the interface also carries the cipo return pin.
//
//   Signals:
//     sclk, copi, ncs    SPI mode-0 pins. They are asynchronous to clk_sys.
//     en_reg_out_7_0     register 0x00
//     en_reg_out_15_8    register 0x01
//     en_reg_pwm_7_0     register 0x02
//     en_reg_pwm_15_8    register 0x03
//     pwm_duty_cycle     register 0x04
//     wr_strobe          one-clk pulse for each committed write
//     wr_addr            address of the last committed write
//     frame_err          sticky malformed-frame flag
//     cipo               serial read data (READBACK_EN only)
//
//   Modports:
//     master  the SPI controller side, which also observes the outputs
//     slave   the register front end
interface spi_reg_frontend_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic       frame_err;
`ifdef READBACK_EN
  logic       cipo;
`endif

  modport master (
`ifdef READBACK_EN
    input  cipo,
`endif
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    input  pwm_duty_cycle, wr_strobe, wr_addr, frame_err
  );

  modport slave (
`ifdef READBACK_EN
    output cipo,
`endif
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
    output pwm_duty_cycle, wr_strobe, wr_addr, frame_err
  );
endinterface

// File: rtl/spi_reg_frontend.sv
// spi_reg_frontend
//   This block is an SPI mode-0 target that receives 16-bit write frames. Each frame is
//   {rw, addr[6:0], data[7:0]}, sent MSB first. The frames update the five 8-bit
//   configuration registers of the PWM peripheral. The SPI pins are synchronized
//   into the clk domain, and the block detects edges on the synchronized signals.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   spi_reg_frontend_if.slave: SPI pins, register outputs, wr_strobe,
//           wr_addr, frame_err (and cipo when READBACK_EN is defined)
//
//   Parameters:
//     SYNC_STAGES  pin synchronizer depth (2 or 3)
//     MAX_ADDR     highest writable address. Writes above it are dropped.
//
//   Optional feature macro: READBACK_EN. It adds cipo readback for read frames.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | wait for the ncs falling edge
//   SHIFT  | shift copi in on each sclk rise, until the ncs rising edge
//   COMMIT | one clk: validate the frame, then write or flag the error
module spi_reg_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_reg_frontend_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  // Only five registers exist, so any address above 4 has no storage.
  localparam int TOP_ADDR = (MAX_ADDR < 4) ? MAX_ADDR : 4;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic sclk_prev, ncs_prev;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  logic [15:0] shift_reg, shift_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        commit_wr, commit_err;

  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       addr_ok;

  logic [7:0] regs [5];
  logic [6:0] wr_addr_q;
  logic       frame_err_q;

  // ncs synchronizes to 1 on reset, so releasing reset never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      copi_sync <= '0;
      ncs_sync  <= '1;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;

  assign frame_rw   = shift_reg[15];
  assign frame_addr = shift_reg[14:8];
  assign frame_data = shift_reg[7:0];
  assign addr_ok    = (frame_addr <= 7'(TOP_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // If an sclk rise and an ncs rise are detected in the same clk, the final bit
  // is still shifted in before the FSM moves to COMMIT.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    cnt_nxt    = cnt;
    commit_wr  = 1'b0;
    commit_err = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          shift_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_nxt = {shift_reg[14:0], copi_s};
          if (cnt != 5'd17) cnt_nxt = cnt + 5'd1;
        end
        if (ncs_rise) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (cnt != 5'd16)          commit_err = 1'b1;
        else if (frame_rw && addr_ok) commit_wr = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) regs[i] <= '0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++)
        if (commit_wr && frame_addr == 7'(i)) regs[i] <= frame_data;
      if (commit_wr)  wr_addr_q   <= frame_addr;
      if (commit_err) frame_err_q <= 1'b1;
    end
  end

  assign bus.en_reg_out_7_0  = regs[0];
  assign bus.en_reg_out_15_8 = regs[1];
  assign bus.en_reg_pwm_7_0  = regs[2];
  assign bus.en_reg_pwm_15_8 = regs[3];
  assign bus.pwm_duty_cycle  = regs[4];
  assign bus.wr_strobe       = commit_wr;
  assign bus.wr_addr         = wr_addr_q;
  assign bus.frame_err       = frame_err_q;

`ifdef READBACK_EN
  logic       sclk_fall;
  logic       rd_load;
  logic [6:0] hdr_addr;
  logic [7:0] rd_byte;
  logic [7:0] tx_shift;
  logic       rd_active;

  assign sclk_fall = ~sclk_s & sclk_prev;
  // On the 8th rise, the header is the seven bits already shifted in plus copi.
  assign hdr_addr  = {shift_reg[5:0], copi_s};
  assign rd_load   = (state == SHIFT) && sclk_rise && (cnt == 5'd7) && !shift_reg[6];

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < 5; i++)
      if (hdr_addr == 7'(i) && hdr_addr <= 7'(TOP_ADDR)) rd_byte = regs[i];
  end

  // The MSB is held through the fall that follows the load, so the controller
  // samples it on the 9th rise. Each later fall, after rise 9 and beyond,
  // advances the shifter by one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift  <= '0;
      rd_active <= 1'b0;
    end else if (state != SHIFT) begin
      tx_shift  <= '0;
      rd_active <= 1'b0;
    end else if (rd_load) begin
      tx_shift  <= rd_byte;
      rd_active <= 1'b1;
    end else if (rd_active && sclk_fall && cnt >= 5'd9) begin
      tx_shift  <= {tx_shift[6:0], 1'b0};
    end
  end

  assign bus.cipo = rd_active & tx_shift[7];
`endif

endmodule

// File: tb/tb_spi_reg_frontend.sv
module tb_spi_reg_frontend;
  localparam int H = 6;  // sclk half period, in clk cycles

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_reg_frontend_if bus();

  spi_reg_frontend #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_regs [5];
  int         m_strobes = 0;
  logic [6:0] m_addr;
  logic       m_err;
  int         strobe_cnt = 0;
`ifdef READBACK_EN
  logic [7:0] rd_cap;
`endif

  always @(posedge clk) if (bus.wr_strobe === 1'b1) strobe_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".r0"}, 32'(bus.en_reg_out_7_0), 32'(m_regs[0]));
    check_val({tag, ".r1"}, 32'(bus.en_reg_out_15_8), 32'(m_regs[1]));
    check_val({tag, ".r2"}, 32'(bus.en_reg_pwm_7_0), 32'(m_regs[2]));
    check_val({tag, ".r3"}, 32'(bus.en_reg_pwm_15_8), 32'(m_regs[3]));
    check_val({tag, ".r4"}, 32'(bus.pwm_duty_cycle), 32'(m_regs[4]));
    check_val({tag, ".strobes"}, 32'(strobe_cnt), 32'(m_strobes));
    check_val({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(m_addr));
    check_val({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_addr = 7'd0;
    m_err  = 1'b0;
  endtask

  // Shift `nbits` bits of `bits` out of the pins, MSB first. Under READBACK_EN,
  // capture cipo just before rises 9..16.
  task automatic spi_frame(input logic [31:0] bits, input int nbits);
`ifdef READBACK_EN
    rd_cap = 8'h00;
`endif
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      bus.copi = bits[nbits-1-i];
      repeat (H) @(negedge clk);
`ifdef READBACK_EN
      if (i >= 8 && i < 16) rd_cap = {rd_cap[6:0], bus.cipo};
`endif
      bus.sclk = 1'b1;
      repeat (H) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    bus.ncs = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic run_frame(input logic [31:0] bits, input int nbits, input string tag);
    logic [6:0] a;
    logic [7:0] exp_rd;
    a = bits[14:8];
    exp_rd = (a <= 7'd4) ? m_regs[a[2:0]] : 8'h00;
    spi_frame(bits, nbits);
    if (nbits != 16) m_err = 1'b1;
    else if (bits[15] && a <= 7'd4) begin
      m_regs[a[2:0]] = bits[7:0];
      m_strobes++;
      m_addr = a;
    end
    check_all(tag);
`ifdef READBACK_EN
    if (nbits == 16 && !bits[15]) check_val({tag, ".cipo"}, 32'(rd_cap), 32'(exp_rd));
`else
    if (exp_rd == 8'hxx) $display("unreachable");
`endif
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    rst      = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_all("reset_idle");

    // sclk activity with ncs high must be ignored
    for (int i = 0; i < 6; i++) begin
      bus.copi = 1'b1;
      bus.sclk = ~bus.sclk;
      repeat (H) @(negedge clk);
    end
    bus.sclk = 1'b0;
    repeat (H) @(negedge clk);
    check_all("sclk_ncs_high");

    run_frame(32'h80F0, 16, "wr_a0");
    run_frame(32'h8480, 16, "wr_a4");
    run_frame(32'h82A5, 16, "wr_a2_b2b");
    run_frame(32'h8733, 16, "wr_a7_drop");
    run_frame(32'h0055, 16, "rd_drop");
    run_frame(32'h81AB >> 1, 15, "short15");
    run_frame(32'h181AB, 17, "long17");
    run_frame(32'h81FF, 16, "wr_a1_after_err");

    for (int k = 0; k < 40; k++) begin
      logic [31:0] f;
      int          nb;
      logic [6:0]  ad;
      nb = ($urandom_range(0, 9) < 8) ? 16 : (($urandom_range(0, 1) == 0) ? 15 : 17);
      ad = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 7));
      f  = {15'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, 8'($urandom)};
      if (nb == 16) f[16] = 1'b0;
      if (nb == 15) f = {17'd0, f[15:1]};
      run_frame(f, nb, $sformatf("rand%0d", k));
    end

    // Reset mid-frame after the 10th bit of 0x8312
    run_frame(32'h8011, 16, "pre_rst_wr");
    @(negedge clk);
    bus.ncs = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bus.copi = 1'(32'h8312 >> (15 - i));
      repeat (H) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (H) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    bus.ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (H) @(negedge clk);
    check_all("mid_frame_rst");
    run_frame(32'h8312, 16, "post_rst_wr");

    run_frame(32'h82A5, 16, "wr_a2_a5");
    run_frame(32'h0200, 16, "rd_a2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
